// File: rtl/csr_spmv_pkg.sv
// Shared types and constants for the CSR sparse-matrix x dense-vector engine.
package csr_spmv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RP_FIRST = 3'd1,
        RP_NEXT  = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4,
        EMIT     = 3'd5
    } state_e;

    // Cycles from the last issued nonzero until its product is in the accumulator.
    localparam int DRAIN_CYCLES = 2;

    function automatic int acc_width(input int data_w, input int guard);
        return 2 * data_w + guard;
    endfunction

endpackage

// File: rtl/csr_mac_lane.sv
// Two-stage multiply-accumulate: stage 1 captures the value and looks up the vector,
// stage 2 adds the sign- or zero-extended product into a wrapping accumulator.
module csr_mac_lane
    import csr_spmv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 14,
    parameter int ACC_GUARD = 8,
    parameter int SIGNED    = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      clear_i,
    input  logic                                      issue_i,
    input  logic [IDX_W-1:0]                          col_rdata_i,
    input  logic [DATA_W-1:0]                         val_rdata_i,
    input  logic [DATA_W-1:0]                         vec_rdata_i,
    output logic [IDX_W-1:0]                          vec_addr_o,
    output logic [acc_width(DATA_W, ACC_GUARD)-1:0]   acc_o
);

    localparam int ACC_W = acc_width(DATA_W, ACC_GUARD);

    logic                v1_q, v2_q;
    logic [DATA_W-1:0]   val_q;
    logic [IDX_W-1:0]    vec_addr_q, vec_addr_d;
    logic [ACC_W-1:0]    acc_q;
    logic [2*DATA_W-1:0] a_ext_s, b_ext_s, prod_s;
    logic [ACC_W-1:0]    prod_ext_s;

    // Stage-1 vector address and the extended product; full-width extension of both
    // operands makes a plain multiply exact for either signedness.
    always_comb begin
        if (v1_q) begin
            vec_addr_d = col_rdata_i;
        end else begin
            vec_addr_d = vec_addr_q;
        end
        if (SIGNED != 0) begin
            a_ext_s    = {{DATA_W{val_q[DATA_W-1]}}, val_q};
            b_ext_s    = {{DATA_W{vec_rdata_i[DATA_W-1]}}, vec_rdata_i};
            prod_s     = a_ext_s * b_ext_s;
            prod_ext_s = {{ACC_GUARD{prod_s[2*DATA_W-1]}}, prod_s};
        end else begin
            a_ext_s    = {{DATA_W{1'b0}}, val_q};
            b_ext_s    = {{DATA_W{1'b0}}, vec_rdata_i};
            prod_s     = a_ext_s * b_ext_s;
            prod_ext_s = {{ACC_GUARD{1'b0}}, prod_s};
        end
    end

    // Stage-valid pipe, value capture and accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            val_q      <= {DATA_W{1'b0}};
            vec_addr_q <= {IDX_W{1'b0}};
            acc_q      <= {ACC_W{1'b0}};
        end else begin
            v1_q       <= issue_i;
            v2_q       <= v1_q;
            vec_addr_q <= vec_addr_d;
            if (v1_q) begin
                val_q <= val_rdata_i;
            end
            if (clear_i) begin
                acc_q <= {ACC_W{1'b0}};
            end else if (v2_q) begin
                acc_q <= acc_q + prod_ext_s;
            end
        end
    end

    assign vec_addr_o = vec_addr_d;
    assign acc_o      = acc_q;

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR SpMV engine: walks the row pointers, streams each row's nonzeros through the
// MAC lane and emits one dot product per row behind a valid/ready handshake.
module csr_spmv_engine
    import csr_spmv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 14,
    parameter int ROW_W     = 10,
    parameter int ACC_GUARD = 8,
    parameter int SIGNED    = 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic                                    start_i,
    input  logic [ROW_W-1:0]                        num_rows_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    rp_err_o,
    output logic [ROW_W:0]                          rp_addr_o,
    input  logic [IDX_W-1:0]                        rp_rdata_i,
    output logic [IDX_W-1:0]                        nz_addr_o,
    input  logic [IDX_W-1:0]                        col_rdata_i,
    input  logic [DATA_W-1:0]                       val_rdata_i,
    output logic [IDX_W-1:0]                        vec_addr_o,
    input  logic [DATA_W-1:0]                       vec_rdata_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [ROW_W-1:0]                        out_row_o,
    output logic [acc_width(DATA_W, ACC_GUARD)-1:0] out_data_o,
    output logic                                    out_zero_o
);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   num_rows_q, num_rows_d, row_q, row_d;
    logic [IDX_W-1:0]   nz_ptr_q, nz_ptr_d, nz_end_q, nz_end_d, nz_addr_q, nz_addr_d;
    logic [ROW_W:0]     rp_addr_q, rp_addr_d;
    logic [1:0]         drain_cnt_q, drain_cnt_d;
    logic               busy_q, busy_d, done_q, done_d, rp_err_q, rp_err_d;
    logic               out_valid_q, out_valid_d, out_zero_q, out_zero_d;
    logic               clear_s, issue_s, accept_s, last_row_s, last_nz_s, drain_end_s;

    // A start landing on the done cycle is refused so passes never overlap.
    assign accept_s    = (state_q == IDLE) && start_i && !done_q;
    assign last_row_s  = (row_q + ROW_W'(1)) == num_rows_q;
    assign last_nz_s   = nz_ptr_q == (nz_end_q - IDX_W'(1));
    assign drain_end_s = drain_cnt_q == 2'(DRAIN_CYCLES - 1);

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && (num_rows_i != {ROW_W{1'b0}})) begin
                    state_d = RP_FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            RP_FIRST: state_d = RP_NEXT;
            RP_NEXT: begin
                if (rp_rdata_i <= nz_ptr_q) begin
                    state_d = EMIT;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_nz_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (drain_end_s) begin
                    state_d = EMIT;
                end else begin
                    state_d = DRAIN;
                end
            end
            EMIT: begin
                if (out_ready_i && last_row_s) begin
                    state_d = IDLE;
                end else if (out_ready_i) begin
                    state_d = RP_NEXT;
                end else begin
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; RAM addresses are issued combinationally so
    // read data lines up with the following state.
    always_comb begin
        num_rows_d  = num_rows_q;
        row_d       = row_q;
        nz_ptr_d    = nz_ptr_q;
        nz_end_d    = nz_end_q;
        nz_addr_d   = nz_addr_q;
        rp_addr_d   = rp_addr_q;
        drain_cnt_d = drain_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rp_err_d    = rp_err_q;
        out_valid_d = out_valid_q;
        out_zero_d  = out_zero_q;
        clear_s     = 1'b0;
        issue_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    num_rows_d = num_rows_i;
                    row_d      = {ROW_W{1'b0}};
                    rp_err_d   = 1'b0;
                    rp_addr_d  = {(ROW_W+1){1'b0}};
                    if (num_rows_i == {ROW_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            RP_FIRST: begin
                nz_ptr_d  = rp_rdata_i;
                rp_addr_d = (ROW_W+1)'(1);
            end
            RP_NEXT: begin
                nz_end_d = rp_rdata_i;
                clear_s  = 1'b1;
                if (rp_rdata_i < nz_ptr_q) begin
                    rp_err_d    = 1'b1;
                    out_valid_d = 1'b1;
                    out_zero_d  = 1'b1;
                end else if (rp_rdata_i == nz_ptr_q) begin
                    out_valid_d = 1'b1;
                    out_zero_d  = 1'b1;
                end else begin
                    out_zero_d = 1'b0;
                end
            end
            STREAM: begin
                issue_s     = 1'b1;
                nz_addr_d   = nz_ptr_q;
                nz_ptr_d    = nz_ptr_q + IDX_W'(1);
                drain_cnt_d = 2'd0;
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_end_s) begin
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    row_d       = row_q + ROW_W'(1);
                    if (last_row_s) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        nz_ptr_d  = nz_end_q;
                        rp_addr_d = {1'b0, row_q} + (ROW_W+1)'(2);
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            num_rows_q  <= {ROW_W{1'b0}};
            row_q       <= {ROW_W{1'b0}};
            nz_ptr_q    <= {IDX_W{1'b0}};
            nz_end_q    <= {IDX_W{1'b0}};
            nz_addr_q   <= {IDX_W{1'b0}};
            rp_addr_q   <= {(ROW_W+1){1'b0}};
            drain_cnt_q <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rp_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            num_rows_q  <= num_rows_d;
            row_q       <= row_d;
            nz_ptr_q    <= nz_ptr_d;
            nz_end_q    <= nz_end_d;
            nz_addr_q   <= nz_addr_d;
            rp_addr_q   <= rp_addr_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rp_err_q    <= rp_err_d;
            out_valid_q <= out_valid_d;
            out_zero_q  <= out_zero_d;
        end
    end

    csr_mac_lane #(
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .ACC_GUARD (ACC_GUARD),
        .SIGNED    (SIGNED)
    ) u_mac (
        .clk_i       (clk_i),
        .rst_ni      (reset_ni),
        .clear_i     (clear_s),
        .issue_i     (issue_s),
        .col_rdata_i (col_rdata_i),
        .val_rdata_i (val_rdata_i),
        .vec_rdata_i (vec_rdata_i),
        .vec_addr_o  (vec_addr_o),
        .acc_o       (out_data_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rp_err_o    = rp_err_q;
    assign rp_addr_o   = rp_addr_d;
    assign nz_addr_o   = nz_addr_d;
    assign out_valid_o = out_valid_q;
    assign out_row_o   = row_q;
    assign out_zero_o  = out_zero_q;

endmodule
